rv32i_lsu: RTL and testbench
============================

Name: rv32i_lsu

Overview:
Parametrised load/store unit that replaces the CPU's fixed single-cycle data-memory path.
- Accepts one load/store request at a time from the core FSM over a valid/ready handshake.
- Generates the aligned word address, byte write mask and shifted write data.
- Waits for memory completion through a bounded wait counter, then returns sign/zero-extended load data with error flags.
- Sits between the core control FSM and the data memory port.

Parameters:
DMEM_WIDTH, 16, byte-address width of the data memory port
MAX_WAIT, 3, maximum WAIT cycles without mem_valid before timeout (must be >= 1)
WAIT_CNT_W, 4, width of the wait counter (must hold MAX_WAIT)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  core request valid
req_ready  out  1  LSU can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  zero-extend load (lbu/lhu)
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-aligned
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data (0 for stores and errors)
rsp_misalign  out  1  access rejected for alignment or illegal size
rsp_timeout  out  1  memory did not answer within MAX_WAIT
mem_req  out  1  memory access strobe
mem_addr  out  DMEM_WIDTH  word-aligned address, low 2 bits forced 0
mem_wmask  out  4  byte write enables (0000 for loads)
mem_wdata  out  32  shifted store data
mem_rdata  in  32  memory read data
mem_valid  in  1  read data valid / write acknowledge

Behaviour:
- Reset (async) values:
  - All outputs 0 except req_ready = 1.
  - State is IDLE, wait counter 0, captured request cleared.
  - Reset mid-operation aborts the access and issues no response.
- States: IDLE, ACCESS, WAIT, ACCESS2, WAIT2 (feature only), RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch the request.
  - If misaligned or size = 11, go to RESP with rsp_misalign = 1 and issue no memory access.
  - Otherwise go to ACCESS.
  - Alignment rules: half requires addr[0] = 0; word requires addr[1:0] = 00.
- ACCESS:
  - mem_req = 1 for exactly one cycle.
  - mem_addr = {addr[DMEM_WIDTH-1:2], 2'b00}.
  - mem_wmask = store ? (base mask << addr[1:0]) : 0, with base mask 0001, 0011 or 1111.
  - mem_wdata = req_wdata << (addr[1:0]*8).
  - Go to WAIT and clear the counter.
- WAIT:
  - mem_valid asserted during an ACCESS cycle is ignored.
  - On mem_valid, capture mem_rdata and go to RESP.
  - Otherwise increment the counter. When the counter reaches MAX_WAIT, go to RESP with rsp_timeout = 1.
  - mem_valid in the same cycle the limit is reached wins: no timeout.
- RESP:
  - rsp_valid = 1 for one cycle, flags held alongside it, then IDLE.
  - req_ready = 0 in every state except IDLE.
- Load extension:
  - Shift the captured word right by addr[1:0]*8.
  - Byte/half sign-extend, or zero-extend if req_unsigned; word is passed unchanged.
- Latency with a zero-wait memory (mem_valid in the first WAIT cycle): request accepted at T, mem_req at T+1, rsp_valid at T+3. Misaligned request: rsp_valid at T+1.
- rsp_rdata = 0 on stores, misalign and timeout.

Optional Feature:
Macro LSU_MISALIGNED_SPLIT_EN.
- Without it: alignment rules above; misaligned accesses return rsp_misalign.
- With it: any byte address is legal for sizes 00–10.
  - Access within one word (offset + bytes <= 4): single access as above.
  - Crossing access: ACCESS/WAIT on word A, then ACCESS2/WAIT2 on word A+4, each with an independent wait counter.
  - Store masks: mask64 = base << off, mem_wmask = mask64[3:0] then mask64[7:4]. wdata64 = wdata << (off*8), sent as low then high word.
  - Load: result = ({w1, w0} >> off*8), then extended.
  - Timeout in the first phase skips the second phase.
  - rsp_misalign is only asserted for size 11.

Test Plan:
1. lw at 0x0010, mem_valid in the first WAIT cycle with rdata 0xDEADBEEF: mem_addr 0x0010, wmask 0000, rsp_rdata 0xDEADBEEF, rsp_valid at T+3.
2. lb at 0x0013, rdata 0x80FFFFFF: rsp_rdata 0xFFFFFF80. lbu at the same address: 0x00000080.
3. sh at 0x0022, wdata 0x0000ABCD: mem_addr 0x0020, wmask 1100, mem_wdata 0xABCD0000, rsp_valid with no flags.
4. lw at 0x0004 with mem_valid never asserted, MAX_WAIT = 3: rsp_timeout = 1 after 3 WAIT cycles, rsp_rdata 0, then req_ready = 1.
5. Without the feature, lw at 0x0006: no mem_req, rsp_misalign = 1 at T+1. With the feature, lw at 0x0006 with words 0x44332211 and 0x88776655: two mem_req pulses (0x0004, 0x0008), rsp_rdata 0x66554433.
6. Assert reset in the WAIT state: req_ready = 1 and mem_req = 0 immediately, no rsp_valid. The next request completes normally.

Source files
------------

// File: rtl/rv32i_lsu.sv
// rv32i_lsu: single-outstanding load/store unit between the core control FSM and data memory.
// Optional macro LSU_MISALIGNED_SPLIT_EN splits word-crossing accesses into two memory phases.
module rv32i_lsu #(
    parameter int DMEM_WIDTH = 16,
    parameter int MAX_WAIT   = 3,
    parameter int WAIT_CNT_W = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [31:0]           i_req_addr,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [31:0]           o_rsp_rdata,
    output logic                  o_rsp_misalign,
    output logic                  o_rsp_timeout,
    output logic                  o_mem_req,
    output logic [DMEM_WIDTH-1:0] o_mem_addr,
    output logic [3:0]            o_mem_wmask,
    output logic [31:0]           o_mem_wdata,
    input  logic [31:0]           i_mem_rdata,
    input  logic                  i_mem_valid
);
    typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACCESS2, S_WAIT2, S_RESP} state_t;

    state_t                r_state;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic [1:0]            r_off;
    logic [1:0]            r_size;
    logic                  r_we;
    logic                  r_unsigned;
    logic                  r_ready;
    logic                  r_mem_req;
    logic [DMEM_WIDTH-1:0] r_mem_addr;
    logic [3:0]            r_mem_wmask;
    logic [31:0]           r_mem_wdata;
    logic                  r_rsp_valid;
    logic [31:0]           r_rsp_rdata;
    logic                  r_rsp_misalign;
    logic                  r_rsp_timeout;

    logic [2:0]            w_nbytes;
    logic [3:0]            w_base;
    logic                  w_bad;
    logic                  w_limit;
    logic [31:0]           w_ld_single;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic                  r_cross;
    logic [DMEM_WIDTH-1:0] r_addr2;
    logic [3:0]            r_mask2;
    logic [31:0]           r_wdata2;
    logic [31:0]           r_w0;
    logic                  w_cross;
    logic [31:0]           w_ld_split;
    logic [7:0]            w_mask;
    logic [63:0]           w_wdata;
`else
    logic [3:0]            w_mask;
    logic [31:0]           w_wdata;
`endif

    function automatic logic [31:0] f_ext(input logic [31:0] v, input logic [1:0] sz, input logic uns);
        case (sz)
            2'b00:   f_ext = {{24{v[7] & ~uns}}, v[7:0]};
            2'b01:   f_ext = {{16{v[15] & ~uns}}, v[15:0]};
            default: f_ext = v;
        endcase
    endfunction

    always_comb begin
        case (i_req_size)
            2'b00:   begin w_nbytes = 3'd1; w_base = 4'b0001; end
            2'b01:   begin w_nbytes = 3'd2; w_base = 4'b0011; end
            default: begin w_nbytes = 3'd4; w_base = 4'b1111; end
        endcase
        w_mask        = '0;
        w_mask[3:0]   = w_base;
        w_mask        = w_mask << i_req_addr[1:0];
        w_wdata       = '0;
        w_wdata[31:0] = i_req_wdata;
        w_wdata       = w_wdata << {i_req_addr[1:0], 3'b000};
`ifdef LSU_MISALIGNED_SPLIT_EN
        w_cross    = ({1'b0, i_req_addr[1:0]} + w_nbytes) > 3'd4;
        w_bad      = (i_req_size == 2'b11);
        w_ld_split = 32'({i_mem_rdata, r_w0} >> {r_off, 3'b000});
`else
        w_bad = (i_req_size == 2'b11)
              | ((i_req_size == 2'b01) & i_req_addr[0])
              | ((i_req_size == 2'b10) & (|i_req_addr[1:0]));
`endif
        w_ld_single = i_mem_rdata >> {r_off, 3'b000};
        w_limit     = (r_cnt == WAIT_CNT_W'(MAX_WAIT - 1));
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_off          <= '0;
            r_size         <= '0;
            r_we           <= 1'b0;
            r_unsigned     <= 1'b0;
            r_ready        <= 1'b1;
            r_mem_req      <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wmask    <= '0;
            r_mem_wdata    <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= '0;
            r_rsp_misalign <= 1'b0;
            r_rsp_timeout  <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            r_cross        <= 1'b0;
            r_addr2        <= '0;
            r_mask2        <= '0;
            r_wdata2       <= '0;
            r_w0           <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (i_req_valid) begin
                    r_ready    <= 1'b0;
                    r_off      <= i_req_addr[1:0];
                    r_size     <= i_req_size;
                    r_we       <= i_req_we;
                    r_unsigned <= i_req_unsigned;
                    if (w_bad) begin
                        r_state        <= S_RESP;
                        r_rsp_valid    <= 1'b1;
                        r_rsp_misalign <= 1'b1;
                        r_rsp_rdata    <= '0;
                    end else begin
                        r_state     <= S_ACCESS;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= {i_req_addr[DMEM_WIDTH-1:2], 2'b00};
                        r_mem_wmask <= i_req_we ? w_mask[3:0] : 4'b0000;
                        r_mem_wdata <= w_wdata[31:0];
`ifdef LSU_MISALIGNED_SPLIT_EN
                        // Second-phase address/mask/data are fixed at accept time.
                        r_cross  <= w_cross;
                        r_addr2  <= {i_req_addr[DMEM_WIDTH-1:2], 2'b00} + DMEM_WIDTH'(4);
                        r_mask2  <= i_req_we ? w_mask[7:4] : 4'b0000;
                        r_wdata2 <= w_wdata[63:32];
`endif
                    end
                end
                S_ACCESS, S_ACCESS2: begin
                    r_mem_req   <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wmask <= '0;
                    r_mem_wdata <= '0;
                    r_cnt       <= '0;
                    r_state     <= (r_state == S_ACCESS) ? S_WAIT : S_WAIT2;
                end
                S_WAIT, S_WAIT2: begin
                    if (i_mem_valid) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                        if (r_state == S_WAIT && r_cross) begin
                            r_w0        <= i_mem_rdata;
                            r_state     <= S_ACCESS2;
                            r_mem_req   <= 1'b1;
                            r_mem_addr  <= r_addr2;
                            r_mem_wmask <= r_mask2;
                            r_mem_wdata <= r_wdata2;
                        end else begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= r_we ? '0 :
                                f_ext(r_cross ? w_ld_split : w_ld_single, r_size, r_unsigned);
                        end
`else
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_we ? '0 : f_ext(w_ld_single, r_size, r_unsigned);
`endif
                    end else if (w_limit) begin
                        r_state       <= S_RESP;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= '0;
                    end else begin
                        r_cnt <= r_cnt + WAIT_CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_rsp_valid    <= 1'b0;
                    r_rsp_rdata    <= '0;
                    r_rsp_misalign <= 1'b0;
                    r_rsp_timeout  <= 1'b0;
                    r_ready        <= 1'b1;
                    r_state        <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ready    = r_ready;
    assign o_mem_req      = r_mem_req;
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_wmask    = r_mem_wmask;
    assign o_mem_wdata    = r_mem_wdata;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_rdata    = r_rsp_rdata;
    assign o_rsp_misalign = r_rsp_misalign;
    assign o_rsp_timeout  = r_rsp_timeout;
endmodule

// File: tb/tb_rv32i_lsu.sv
// tb_rv32i_lsu: directed bench for rv32i_lsu with a transaction-level expectation model.
// Follows LSU_MISALIGNED_SPLIT_EN so the same bench covers both builds.
module tb_rv32i_lsu;
    localparam int DW = 16;
    localparam int MW = 3;
`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct {
        logic        mreq;
        logic [15:0] maddr;
        logic [3:0]  mmask;
        logic [31:0] mwdata;
        logic        rv;
        logic [31:0] rd;
        logic        mis;
        logic        to;
        logic        rdy;
    } exp_t;

    logic          clk, rst;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]    req_size;
    logic [31:0]   req_addr, req_wdata;
    logic          rsp_valid, rsp_misalign, rsp_timeout;
    logic [31:0]   rsp_rdata;
    logic          mem_req, mem_valid;
    logic [DW-1:0] mem_addr;
    logic [3:0]    mem_wmask;
    logic [31:0]   mem_wdata, mem_rdata;

    rv32i_lsu #(.DMEM_WIDTH(DW), .MAX_WAIT(MW), .WAIT_CNT_W(4)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_size(req_size), .i_req_unsigned(req_unsigned),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
        .o_rsp_misalign(rsp_misalign), .o_rsp_timeout(rsp_timeout),
        .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_mem_wmask(mem_wmask),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_valid(mem_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, t0 = 0;
    bit mon_en = 1'b0;
    exp_t q[$];

    int lat[2];
    logic [31:0] wv[2];
    bit noise = 1'b0;
    int ph = 0, wcnt = -1, cur = 0;

    int mreq_cnt = 0, last_lat = -1;
    logic [31:0] last_rd, first_maddr, last_maddr, last_mask, last_wdata;
    logic last_mis, last_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t blank();
        exp_t e;
        e.mreq = 0; e.maddr = 0; e.mmask = 0; e.mwdata = 0;
        e.rv = 0; e.rd = 0; e.mis = 0; e.to = 0; e.rdy = 0;
        return e;
    endfunction

    // Expected per-cycle outputs, starting with the cycle after acceptance.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int off, nb, nph;
        bit to;
        logic [63:0] m64, d64, r64;
        logic [31:0] v, rd;
        off = int'(addr % 4);
        nb  = (sz == 2'b11) ? 0 : (1 << sz);
        if (nb == 0 || (!SPLIT && (off % nb) != 0)) begin
            e = blank(); e.rv = 1; e.mis = 1; e.rd = 0;
            q.push_back(e);
            return;
        end
        nph = (SPLIT && (off + nb) > 4) ? 2 : 1;
        m64 = we ? (((64'd1 << nb) - 64'd1) << off) : 64'd0;
        d64 = {32'd0, wd} << (8 * off);
        to  = 0;
        for (int p = 0; p < nph && !to; p++) begin
            e = blank();
            e.mreq   = 1;
            e.maddr  = 16'((addr & ~32'd3) + 32'(4 * p));
            e.mmask  = 4'(m64 >> (4 * p));
            e.mwdata = 32'(d64 >> (32 * p));
            q.push_back(e);
            if (lat[p] < MW) repeat (lat[p] + 1) q.push_back(blank());
            else begin
                repeat (MW) q.push_back(blank());
                to = 1;
            end
        end
        r64 = (nph == 2) ? {wv[1], wv[0]} : {32'd0, wv[0]};
        v = 32'(r64 >> (8 * off));
        if (nb == 1) begin
            rd = v & 32'hFF;
            if (!uns && v[7]) rd = rd | 32'hFFFF_FF00;
        end else if (nb == 2) begin
            rd = v & 32'hFFFF;
            if (!uns && v[15]) rd = rd | 32'hFFFF_0000;
        end else rd = v;
        if (we || to) rd = 0;
        e = blank(); e.rv = 1; e.to = to; e.rd = rd;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (mon_en) begin
            if (q.size() != 0) e = q.pop_front();
            else begin
                e = blank(); e.rdy = 1;
            end
            chk("req_ready", 32'(req_ready), 32'(e.rdy));
            chk("mem_req", 32'(mem_req), 32'(e.mreq));
            chk("rsp_valid", 32'(rsp_valid), 32'(e.rv));
            if (e.mreq) begin
                chk("mem_addr", 32'(mem_addr), 32'(e.maddr));
                chk("mem_wmask", 32'(mem_wmask), 32'(e.mmask));
                chk("mem_wdata", mem_wdata, e.mwdata);
            end
            if (e.rv) begin
                chk("rsp_rdata", rsp_rdata, e.rd);
                chk("rsp_misalign", 32'(rsp_misalign), 32'(e.mis));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
            end
            if (mem_req) begin
                if (mreq_cnt == 0) first_maddr = 32'(mem_addr);
                mreq_cnt++;
                last_maddr = 32'(mem_addr);
                last_mask  = 32'(mem_wmask);
                last_wdata = mem_wdata;
            end
            if (rsp_valid) begin
                last_rd  = rsp_rdata;
                last_mis = rsp_misalign;
                last_to  = rsp_timeout;
                last_lat = cyc - t0;
            end
        end
    end

    // Memory responder: mem_valid arrives lat[p] cycles into the WAIT phase (noise pulses it during ACCESS).
    initial begin
        mem_valid = 0;
        mem_rdata = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_valid = 0;
                wcnt = -1;
            end else if (mem_req) begin
                mem_valid = noise;
                mem_rdata = noise ? 32'hBAD0_BAD0 : 32'h0;
                cur  = (ph > 1) ? 1 : ph;
                ph   = ph + 1;
                wcnt = 0;
            end else if (wcnt >= 0) begin
                if (wcnt == lat[cur]) begin
                    mem_valid = 1;
                    mem_rdata = wv[cur];
                    wcnt = -1;
                end else begin
                    mem_valid = 0;
                    wcnt++;
                end
            end else mem_valid = 0;
        end
    end

    task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int l0, input int l1, input logic [31:0] d0, input logic [31:0] d1,
                       input bit nz);
        @(negedge clk); #1;
        lat[0] = l0; lat[1] = l1; wv[0] = d0; wv[1] = d1;
        noise = nz; ph = 0; wcnt = -1; mreq_cnt = 0; last_lat = -1;
        last_rd = 32'h0BAD_F00D; last_mis = 1'bx; last_to = 1'bx;
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1;
        t0 = cyc;
        model(we, sz, uns, addr, wd);
        @(posedge clk); #1;
        req_valid = 0;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A; req_size = 2'b11; req_we = ~we;
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 0; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0;
        lat[0] = 0; lat[1] = 0; wv[0] = 0; wv[1] = 0;
        #1 rst = 1;
        #2;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_flags", {30'd0, rsp_misalign, rsp_timeout}, 32'd0);
        @(posedge clk); @(posedge clk); #1 rst = 0;
        mon_en = 1;

        // lw zero-wait
        txn(0, 2'b10, 0, 32'h0010, 0, 0, 0, 32'hDEAD_BEEF, 0, 0);
        chk("lw_rdata", last_rd, 32'hDEAD_BEEF);
        chk("lw_latency", 32'(last_lat), 32'd3);
        chk("lw_addr", last_maddr, 32'h0010);
        chk("lw_wmask", last_mask, 32'h0);
        // lb / lbu
        txn(0, 2'b00, 0, 32'h0013, 0, 0, 0, 32'h80FF_FFFF, 0, 0);
        chk("lb_rdata", last_rd, 32'hFFFF_FF80);
        txn(0, 2'b00, 1, 32'h0013, 0, 0, 0, 32'h80FF_FFFF, 0, 0);
        chk("lbu_rdata", last_rd, 32'h0000_0080);
        // sh, one wait cycle
        txn(1, 2'b01, 0, 32'h0022, 32'h0000_ABCD, 1, 0, 32'h1234_5678, 0, 0);
        chk("sh_addr", last_maddr, 32'h0020);
        chk("sh_wmask", last_mask, 32'hC);
        chk("sh_wdata", last_wdata, 32'hABCD_0000);
        chk("sh_rsp", {last_rd[29:0], last_mis, last_to}, 32'h0);
        chk("sh_latency", 32'(last_lat), 32'd4);
        // lw timeout
        txn(0, 2'b10, 0, 32'h0004, 0, 99, 0, 32'h1111_1111, 0, 0);
        chk("to_flag", 32'(last_to), 32'd1);
        chk("to_rdata", last_rd, 32'd0);
        chk("to_latency", 32'(last_lat), 32'd5);
        // lw at 0x0006
        txn(0, 2'b10, 0, 32'h0006, 0, 0, 0, 32'h4433_2211, 32'h8877_6655, 0);
`ifdef LSU_MISALIGNED_SPLIT_EN
        chk("split_rdata", last_rd, 32'h6655_4433);
        chk("split_mreqs", 32'(mreq_cnt), 32'd2);
        chk("split_addr0", first_maddr, 32'h0004);
        chk("split_addr1", last_maddr, 32'h0008);
`else
        chk("mis_flag", 32'(last_mis), 32'd1);
        chk("mis_latency", 32'(last_lat), 32'd1);
        chk("mis_mreqs", 32'(mreq_cnt), 32'd0);
`endif
        // lh / lhu, sb, limit-cycle mem_valid with ACCESS noise, timeout, illegal size
        txn(0, 2'b01, 0, 32'h0002, 0, 0, 0, 32'h8001_1234, 0, 0);
        chk("lh_rdata", last_rd, 32'hFFFF_8001);
        txn(0, 2'b01, 1, 32'h0002, 0, 0, 0, 32'h8001_1234, 0, 0);
        chk("lhu_rdata", last_rd, 32'h0000_8001);
        txn(1, 2'b00, 0, 32'h0001, 32'h1234_56AB, 0, 0, 0, 0, 0);
        chk("sb_wmask", last_mask, 32'h2);
        chk("sb_wdata", last_wdata, 32'h3456_AB00);
        txn(1, 2'b10, 0, 32'h0008, 32'hCAFE_F00D, 2, 0, 0, 0, 1);
        chk("limit_no_to", 32'(last_to), 32'd0);
        chk("limit_latency", 32'(last_lat), 32'd5);
        txn(0, 2'b10, 0, 32'h000C, 0, 3, 0, 32'h7777_7777, 0, 0);
        chk("limit_to", 32'(last_to), 32'd1);
        txn(0, 2'b11, 0, 32'h0000, 0, 0, 0, 32'h7777_7777, 0, 0);
        chk("size11_mis", 32'(last_mis), 32'd1);
        // crossing accesses (misaligned in the default build)
        txn(1, 2'b10, 0, 32'h000E, 32'hAABB_CCDD, 0, 1, 0, 0, 0);
        txn(0, 2'b01, 1, 32'h0003, 0, 1, 0, 32'h1122_3344, 32'h5566_7788, 0);
`ifdef LSU_MISALIGNED_SPLIT_EN
        chk("split_lhu", last_rd, 32'h0000_8811);
`endif
        txn(0, 2'b10, 0, 32'h0006, 0, 99, 0, 32'h1, 32'h2, 0);
        txn(0, 2'b01, 0, 32'h0007, 0, 0, 99, 32'h1, 32'h2, 0);

        // reset while in WAIT
        mon_en = 0;
        @(negedge clk); #1;
        lat[0] = 99; lat[1] = 99; noise = 0; ph = 0; wcnt = -1;
        req_we = 0; req_size = 2'b10; req_unsigned = 0; req_addr = 32'h0004; req_valid = 1;
        @(posedge clk); #1 req_valid = 0;
        chk("abort_busy", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("abort_wait_mreq", 32'(mem_req), 32'd0);
        rst = 1; #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        q.delete();
        mon_en = 1;
        txn(0, 2'b10, 0, 32'h0010, 0, 0, 0, 32'hC001_D00D, 0, 0);
        chk("post_rst_rdata", last_rd, 32'hC001_D00D);
        chk("post_rst_latency", 32'(last_lat), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by %0t want finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
